// File: rtl/seq_alu_if.sv
// Command/result bus of seq_alu: command handshake, result handshake, flags and busy.
// master drives commands and out_ready; slave is the ALU side.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, r, hi, zero, carry, negative, overflow, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, r, hi, zero, carry, negative, overflow, busy
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops plus WIDTH-cycle shift-add multiply and restoring divide.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise DIV/DIVU finish in one cycle with overflow=1.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam int unsigned MSB  = WIDTH - 1;

    localparam logic [4:0] OP_ADDU  = 5'b00000, OP_ADD  = 5'b00001, OP_SUB  = 5'b00010,
                           OP_SUBU  = 5'b00011, OP_AND  = 5'b00100, OP_OR   = 5'b00101,
                           OP_XOR   = 5'b00110, OP_NOR  = 5'b00111, OP_SLL  = 5'b01000,
                           OP_SRL   = 5'b01001, OP_SRA  = 5'b01010, OP_SLLV = 5'b01011,
                           OP_LUI   = 5'b01101, OP_SRLV = 5'b01110, OP_SRAV = 5'b01111,
                           OP_ADDL  = 5'b10001, OP_SLT  = 5'b10010, OP_SLTU = 5'b10011,
                           OP_MULT  = 5'b10100, OP_MULTU = 5'b10101, OP_DIV = 5'b10110,
                           OP_DIVU  = 5'b10111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_r, r_hi, r_acc_hi, r_acc_lo, r_opd;
    logic             r_zero, r_carry, r_neg, r_ovf, r_neg_q;
    logic [SH_W-1:0]  r_cnt;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] r_a;
    logic             r_is_div, r_neg_r, r_dbz, r_dov;
    logic [WIDTH:0]   w_rsh, w_diff;
`endif

    logic [WIDTH-1:0] w_r, w_abs_a, w_abs_b, w_step_hi, w_step_lo, w_fin_r, w_fin_hi;
    logic [WIDTH:0]   w_sum, w_dif, w_madd;
    logic [2*WIDTH-1:0] w_prod;
    logic [SH_W-1:0]  w_sh;
    logic             w_c, w_n, w_v, w_big, w_sgn, w_iter, w_fin_v;

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state == CALC);
    assign bus.out_valid = (r_state == DONE);
    assign bus.r         = r_r;
    assign bus.hi        = r_hi;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.negative  = r_neg;
    assign bus.overflow  = r_ovf;

    assign w_sgn   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_abs_a = (w_sgn && bus.a[MSB]) ? -bus.a : bus.a;
    assign w_abs_b = (w_sgn && bus.b[MSB]) ? -bus.b : bus.b;
`ifdef SEQ_ALU_DIV_EN
    assign w_iter  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
`else
    assign w_iter  = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`endif

    // Single-cycle result and flags
    always_comb begin
        w_r   = '0;
        w_c   = 1'b0;
        w_n   = 1'b0;
        w_v   = 1'b0;
        w_sum = {1'b0, bus.a} + {1'b0, bus.b};
        w_dif = {1'b0, bus.a} - {1'b0, bus.b};
        w_big = (bus.a >= WIDTH'(WIDTH));
        w_sh  = bus.a[SH_W-1:0];
        case (bus.op)
            OP_ADDU: begin w_r = w_sum[MSB:0]; w_c = w_sum[WIDTH]; w_n = w_r[MSB]; end
            OP_ADD: begin
                w_r = w_sum[MSB:0];
                w_n = w_r[MSB];
                w_v = (bus.a[MSB] == bus.b[MSB]) && (w_r[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                w_r = w_dif[MSB:0];
                w_n = w_r[MSB];
                w_v = (bus.a[MSB] != bus.b[MSB]) && (w_r[MSB] != bus.a[MSB]);
            end
            OP_SUBU: begin w_r = w_dif[MSB:0]; w_c = w_dif[WIDTH]; w_n = w_r[MSB]; end
            OP_AND:  w_r = bus.a & bus.b;
            OP_OR:   w_r = bus.a | bus.b;
            OP_XOR:  w_r = bus.a ^ bus.b;
            OP_NOR:  w_r = ~(bus.a | bus.b);
            OP_SLL:  w_r = w_big ? '0 : (bus.b << w_sh);
            OP_SRL:  w_r = w_big ? '0 : (bus.b >> w_sh);
            OP_SRA:  w_r = w_big ? {WIDTH{bus.b[MSB]}} : WIDTH'($signed(bus.b) >>> w_sh);
            OP_SLLV: w_r = bus.b << w_sh;
            OP_SRLV: w_r = bus.b >> w_sh;
            OP_SRAV: w_r = WIDTH'($signed(bus.b) >>> w_sh);
            OP_LUI:  w_r = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ADDL: w_r = w_sum[MSB:0];
            OP_SLT:  begin w_r = WIDTH'($signed(bus.a) < $signed(bus.b)); w_n = w_r[MSB]; end
            OP_SLTU: begin w_r = WIDTH'(w_dif[WIDTH]); w_c = w_dif[WIDTH]; end
            OP_DIV, OP_DIVU: w_v = 1'b1;
            default: w_r = '0;
        endcase
    end

    // One iteration: shift-add multiply step, or restoring divide step
    always_comb begin
        w_madd    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opd} : '0);
        w_step_hi = w_madd[WIDTH:1];
        w_step_lo = {w_madd[0], r_acc_lo[MSB:1]};
`ifdef SEQ_ALU_DIV_EN
        w_rsh  = {r_acc_hi, r_acc_lo[MSB]};
        w_diff = w_rsh - {1'b0, r_opd};
        if (r_is_div) begin
            w_step_hi = w_diff[WIDTH] ? w_rsh[MSB:0] : w_diff[MSB:0];
            w_step_lo = {r_acc_lo[MSB-1:0], ~w_diff[WIDTH]};
        end
`endif
    end

    // Sign correction and exception overrides applied on the last iteration
    always_comb begin
        w_prod   = r_neg_q ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
        w_fin_r  = w_prod[MSB:0];
        w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fin_v  = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        if (r_is_div) begin
            w_fin_r  = r_neg_q ? -w_step_lo : w_step_lo;
            w_fin_hi = r_neg_r ? -w_step_hi : w_step_hi;
            if (r_dbz) begin
                w_fin_r  = '1;
                w_fin_hi = r_a;
                w_fin_v  = 1'b1;
            end else if (r_dov) begin
                w_fin_r  = {1'b1, {(WIDTH-1){1'b0}}};
                w_fin_hi = '0;
                w_fin_v  = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_r      <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opd    <= '0;
            r_neg_q  <= 1'b0;
            r_cnt    <= '0;
`ifdef SEQ_ALU_DIV_EN
            r_a      <= '0;
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_dov    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    if (w_iter) begin
                        r_acc_hi <= '0;
                        r_acc_lo <= w_abs_a;
                        r_opd    <= w_abs_b;
                        r_neg_q  <= w_sgn && (bus.a[MSB] ^ bus.b[MSB]);
                        r_cnt    <= SH_W'(WIDTH - 1);
`ifdef SEQ_ALU_DIV_EN
                        r_is_div <= bus.op[1];
                        r_neg_r  <= w_sgn && bus.a[MSB];
                        r_a      <= bus.a;
                        r_dbz    <= (bus.b == '0);
                        r_dov    <= (bus.op == OP_DIV) && (bus.b == '1) &&
                                    (bus.a == {1'b1, {(WIDTH-1){1'b0}}});
`endif
                        r_state  <= CALC;
                    end else begin
                        r_r     <= w_r;
                        r_hi    <= '0;
                        r_zero  <= (w_r == '0);
                        r_carry <= w_c;
                        r_neg   <= w_n;
                        r_ovf   <= w_v;
                        r_state <= DONE;
                    end
                end
                CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt - SH_W'(1);
                    if (r_cnt == '0) begin
                        r_r     <= w_fin_r;
                        r_hi    <= w_fin_hi;
                        r_zero  <= (w_fin_r == '0);
                        r_carry <= 1'b0;
                        r_neg   <= 1'b0;
                        r_ovf   <= w_fin_v;
                        r_state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning op/a/b are presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a command this cycle.
REQ-006 The block SHALL have ports op, input, 5 bits, and a and b, inputs, WIDTH bits each, meaning operation code and operands.
REQ-007 The block SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit, meaning the result handshake.
REQ-008 The block SHALL have ports r and hi, outputs, WIDTH bits each, meaning result/low product/quotient and high product/remainder.
REQ-009 The block SHALL have ports zero, carry, negative and overflow, outputs, 1 bit each, meaning result flags.
REQ-010 The block SHALL have port busy, output, 1 bit, high while an iterative operation is in progress.

Function
REQ-011 The op encodings SHALL be: ADDU 00000, ADD 00001, SUB 00010, SUBU 00011, AND 00100, OR 00101, XOR 00110, NOR 00111, SLL 01000, SRL 01001, SRA 01010, SLLV 01011, LUI 01101, SRLV 01110, SRAV 01111, ADDL 10001, SLT 10010, SLTU 10011, MULT 10100, MULTU 10101, DIV 10110, DIVU 10111; ADDL is the load/store address add, signed add with overflow forced 0.
REQ-012 States SHALL be IDLE, CALC and DONE; in_ready = (state==IDLE); a command is accepted on a clock edge with in_valid&&in_ready.
REQ-013 Single-cycle ops (all except MULT, MULTU, DIV, DIVU) SHALL go IDLE->DONE, with r, hi and flags registered at acceptance and out_valid high the next cycle, i.e. latency 1.
REQ-014 Iterative ops SHALL go IDLE->CALC for exactly WIDTH cycles, with MULT/MULTU as shift-add and DIV/DIVU as restoring division one bit per cycle, then CALC->DONE; latency is WIDTH+1 cycles; busy = (state==CALC).
REQ-015 In DONE, r/hi/flags SHALL be held stable while out_valid=1; DONE->IDLE on out_ready; in_valid is ignored outside IDLE.
REQ-016 SLL/SRL/SRA SHALL shift b by the full value of a, with result 0 (SRA: sign fill) when a>=WIDTH; SLLV/SRLV/SRAV SHALL use only a[log2(WIDTH)-1:0].
REQ-017 LUI SHALL give r = {b[WIDTH/2-1:0], WIDTH/2 zeros}; SLT/SLTU SHALL give r = 1 or 0; hi SHALL be 0 for all single-cycle ops.
REQ-018 Flag zero SHALL be (r==0) for all ops.
REQ-019 Flag carry SHALL be the carry-out for ADDU, the borrow (a<b unsigned) for SUBU/SLTU, and 0 otherwise, never Z.
REQ-020 Flag negative SHALL be r[WIDTH-1] for ADD/SUB/ADDU/SUBU/SLT and 0 otherwise.
REQ-021 Flag overflow SHALL be the signed two's-complement overflow for ADD/SUB, 1 on divide exceptions (REQ-022), and 0 otherwise.
REQ-022 Division by zero SHALL give r = all ones and hi = a with overflow=1; DIV with MIN/-1 SHALL give r = MIN and hi = 0 with overflow=1; both still take WIDTH+1 cycles.
REQ-023 MULT/DIV SHALL return signed results; the DIV remainder SHALL take the sign of the dividend and the quotient SHALL truncate toward zero.
REQ-024 An undefined op SHALL complete as single-cycle with r=0, hi=0, zero=1 and all other flags 0.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, with out_valid=0, busy=0, in_ready=1, r=0, hi=0 and all flags 0, including mid-CALC; no partial result survives.
REQ-026 The first command SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro SEQ_ALU_DIV_EN defined, DIV/DIVU SHALL behave as in REQ-014/022/023.
REQ-028 Without SEQ_ALU_DIV_EN, DIV/DIVU SHALL complete single-cycle with r=0, hi=0 and overflow=1, and no divider logic SHALL be synthesised; MULT/MULTU are unaffected.

Verification
REQ-029 ADD, WIDTH=32, a=7FFFFFFF, b=1 -> r=80000000, overflow=1, negative=1, out_valid one cycle after acceptance.
REQ-030 MULT, a=FFFFFFFE(-2), b=3 -> after 33 cycles, hi=FFFFFFFF, r=FFFFFFFA; busy high for exactly 32 cycles.
REQ-031 DIV, a=FFFFFFF9(-7), b=2 -> r=FFFFFFFD, hi=FFFFFFFF; DIVU with b=0 -> r=FFFFFFFF, hi=a, overflow=1.
REQ-032 out_ready held low for 5 cycles after out_valid -> r/flags stable, in_ready=0 and a new in_valid is ignored; in_ready=1 the cycle after out_ready.
REQ-033 rst_n pulsed low at CALC cycle 10 of MULTU -> out_valid=0 and in_ready=1 immediately; next ADDU 1+1 -> r=2.
REQ-034 WIDTH=16, SRA a=20, b=8000 -> r=FFFF; SRAV with the same operands (shift 4) -> r=F800.
